fp_mult_seq: RTL and testbench

- Multi-cycle multiplier for the 16-bit distance-path float format. It sits directly upstream of the float adder and produces the products (v·v, v·sin/cos terms) that the adder sums.
- Operands and results use the same 5-bit exponent / 11-bit fraction packing the adder consumes.
- Iterative shift-add datapath with valid/ready handshakes on input and output; one operation in flight.

---
 rtl/fp_mult_seq.sv | 135 +++++++++++++
 tb/tb_fp_mult_seq.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/fp_mult_seq.sv
// fp_mult_seq: multi-cycle multiplier for the 16-bit unsigned distance-path float.
// Format: {exp[4:0], frac[10:0]}, value = 1.frac * 2^(exp-15). exp==0 means zero.
// There are no denormals and no inf/NaN; exp 31 is an ordinary exponent.
// The 12x12 mantissa product is built one shift-add step per cycle. Exactly one
// operation is in flight, and the result appears 13 cycles after the accept edge.
//
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   in_valid/in_ready   operand handshake; a and b are sampled on the accept edge
//   a, b                operands
//   out_valid/out_ready product handshake; prod/ovf/unf are held until it completes
//   prod                product; truncated, saturated to 16'hFFFF, or flushed to 0
//   ovf, unf            saturation / underflow-flush flags, qualified by out_valid
module fp_mult_seq #(
  parameter int unsigned EXP_W  = 5,
  parameter int unsigned FRAC_W = 11,
  parameter int unsigned BIAS   = 15
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [EXP_W+FRAC_W-1:0] a,
  input  logic [EXP_W+FRAC_W-1:0] b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+FRAC_W-1:0] prod,
  output logic                    ovf,
  output logic                    unf
);

  localparam int unsigned MantW = FRAC_W + 1;
  localparam int unsigned AccW  = 2 * MantW;
  localparam int unsigned CntW  = $clog2(MantW);
  localparam int unsigned WordW = EXP_W + FRAC_W;
  localparam logic [CntW-1:0] LastCnt = CntW'(MantW - 1);

  typedef enum logic [1:0] {StIdle, StMul, StNorm, StDone} state_e;

  state_e              state_q;
  logic [MantW-1:0]    ma_q, mb_q;
  logic [EXP_W-1:0]    ea_q, eb_q;
  logic                z_q;
  logic [AccW-1:0]     acc_q;
  logic [CntW-1:0]     cnt_q;

  // Normalisation of the finished product.
  logic signed [6:0]   e_sum;
  logic [FRAC_W-1:0]   f_norm;

  always_comb begin
    e_sum  = $signed({2'b00, ea_q}) + $signed({2'b00, eb_q}) - 7'(BIAS);
    f_norm = acc_q[AccW-3 -: FRAC_W];
    // Product of two 1.x mantissas lies in [1,4); a set top bit means >= 2.
    if (acc_q[AccW-1]) begin
      e_sum  = e_sum + 7'sd1;
      f_norm = acc_q[AccW-2 -: FRAC_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      prod      <= '0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
      ma_q      <= '0;
      mb_q      <= '0;
      ea_q      <= '0;
      eb_q      <= '0;
      z_q       <= 1'b0;
      acc_q     <= '0;
      cnt_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid && in_ready) begin
            ma_q     <= {1'b1, a[FRAC_W-1:0]};
            mb_q     <= {1'b1, b[FRAC_W-1:0]};
            ea_q     <= a[WordW-1:FRAC_W];
            eb_q     <= b[WordW-1:FRAC_W];
            z_q      <= (a[WordW-1:FRAC_W] == '0) || (b[WordW-1:FRAC_W] == '0);
            acc_q    <= '0;
            cnt_q    <= '0;
            in_ready <= 1'b0;
            state_q  <= StMul;
          end
        end
        StMul: begin
          if (mb_q[cnt_q]) begin
            acc_q <= acc_q + ({{(AccW-MantW){1'b0}}, ma_q} << cnt_q);
          end
          if (cnt_q == LastCnt) begin
            state_q <= StNorm;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StNorm: begin
          // Zero operands still take the full latency so timing never depends on data.
          if (z_q) begin
            prod <= '0;
            ovf  <= 1'b0;
            unf  <= 1'b0;
          end else if (e_sum > 7'sd31) begin
            prod <= '1;
            ovf  <= 1'b1;
            unf  <= 1'b0;
          end else if (e_sum <= 7'sd0) begin
            prod <= '0;
            ovf  <= 1'b0;
            unf  <= 1'b1;
          end else begin
            prod <= {e_sum[EXP_W-1:0], f_norm};
            ovf  <= 1'b0;
            unf  <= 1'b0;
          end
          out_valid <= 1'b1;
          state_q   <= StDone;
        end
        StDone: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mult_seq.sv
// Directed self-checking bench for fp_mult_seq. Inputs are driven 1 time unit
// after each rising edge, and outputs are sampled at that same point.
module tb_fp_mult_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] prod;
  logic        ovf, unf;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  fp_mult_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .prod     (prod),
    .ovf      (ovf),
    .unf      (unf)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Waits for out_valid, bounded; returns the number of edges after the accept edge.
  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic finish_xfer(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_val({tag, "_ov_drop"}, 32'(out_valid), 32'd0);
    check_val({tag, "_rdy_back"}, 32'(in_ready), 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                        input logic [15:0] ep, input logic eo, input logic eu);
    int lat;
    check_val({tag, "_rdy_pre"}, 32'(in_ready), 32'd1);
    a = av; b = bv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out(lat);
    check_val({tag, "_lat"}, 32'(lat), 32'd13);
    check_val({tag, "_prod"}, 32'(prod), 32'(ep));
    check_val({tag, "_ovf"}, 32'(ovf), 32'(eo));
    check_val({tag, "_unf"}, 32'(unf), 32'(eu));
    finish_xfer(tag);
  endtask

  initial begin
    int lat;
    int seen;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    #12;
    check_val("rst_in_ready", 32'(in_ready), 32'd1);
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_prod", 32'(prod), 32'h0);
    check_val("rst_ovf", 32'(ovf), 32'd0);
    check_val("rst_unf", 32'(unf), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("one_x_one", 16'h7800, 16'h7800, 16'h7800, 1'b0, 1'b0);
    run_op("carry_1p5", 16'h7C00, 16'h7C00, 16'h8100, 1'b0, 1'b0);
    run_op("two_x_1p5", 16'h8000, 16'h7C00, 16'h8400, 1'b0, 1'b0);
    run_op("sat", 16'hF800, 16'h8000, 16'hFFFF, 1'b1, 1'b0);
    run_op("flush", 16'h0800, 16'h0800, 16'h0000, 1'b0, 1'b1);
    run_op("zero_a", 16'h0000, 16'h7800, 16'h0000, 1'b0, 1'b0);
    run_op("zero_b_frac", 16'h7C00, 16'h07FF, 16'h0000, 1'b0, 1'b0);

    // Backpressure: result held for 20 cycles with out_ready low.
    a = 16'h7C00; b = 16'h7C00; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out(lat);
    check_val("bp_lat", 32'(lat), 32'd13);
    for (int i = 0; i < 20; i++) begin
      check_val("bp_ov_hold", 32'(out_valid), 32'd1);
      check_val("bp_prod_hold", 32'(prod), 32'h8100);
      check_val("bp_rdy_low", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    finish_xfer("bp");
    check_val("bp_prod_kept", 32'(prod), 32'h8100);

    // Busy: in_valid stays high with changing operands during the operation.
    a = 16'h7800; b = 16'h7800; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 16'hF800;
    lat = 0;
    seen = 0;
    while (!out_valid && lat < 40) begin
      b = b ^ 16'h5A5A;
      if (in_ready) seen++;
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    check_val("busy_no_accept", 32'(seen), 32'd0);
    check_val("busy_lat", 32'(lat), 32'd13);
    check_val("busy_prod", 32'(prod), 32'h7800);
    finish_xfer("busy");

    // Mid-operation reset, asserted between clock edges.
    a = 16'h7C00; b = 16'h7C00; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_val("mrst_in_ready", 32'(in_ready), 32'd1);
    check_val("mrst_out_valid", 32'(out_valid), 32'd0);
    check_val("mrst_prod", 32'(prod), 32'h0);
    check_val("mrst_ovf", 32'(ovf), 32'd0);
    check_val("mrst_unf", 32'(unf), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    check_val("mrst_no_out", 32'(seen), 32'd0);
    run_op("post_rst", 16'h7800, 16'h7800, 16'h7800, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
